// File: rtl/vc_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : params_noc
// Description : NoC sizing constants, port enumeration and index packing helper
// Revision    : 1.0
// ============================================================================
package params_noc;

    localparam int PORT_NUM = 5;
    localparam int VC_NUM   = 2;
    localparam int VC_Size  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int REQ_NUM  = PORT_NUM * VC_NUM;
    localparam int PORT_W   = 3;

    typedef enum logic [PORT_W-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } inout_Port;

    // Flattened index of (port, vc) or (in_port, in_vc) pairs.
    function automatic int pack_idx(input int major, input int minor, input int minor_num);
        return major * minor_num + minor;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vc_allocator_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with registered pointer, one-hot grant
// Revision    : 1.0
// ============================================================================
module rr_arbiter
    import params_noc::*;
#(
    parameter  int N     = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         grant_valid
);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] idx;
    int               sum;

    // Search starts at ptr and wraps at N-1, which need not be a power of two.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        winner      = '0;
        idx         = '0;
        sum         = 0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) sum = sum - N;
            idx = PTR_W'(sum);
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_valid = 1'b1;
                winner      = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= (winner == PTR_W'(N - 1)) ? '0 : winner + PTR_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vc_allocator.sv
`default_nettype none
// ============================================================================
// Module      : vc_allocator
// Description : Router VC allocator, one round-robin grant per output port
// Revision    : 1.0
// ============================================================================
module vc_allocator #(
    parameter  int PORT_NUM = params_noc::PORT_NUM,
    parameter  int VC_NUM   = params_noc::VC_NUM,
    localparam int REQ_NUM  = PORT_NUM * VC_NUM,
    localparam int VC_Size  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int PORT_W   = params_noc::PORT_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQ_NUM-1:0]               vc_Req,
    input  logic [REQ_NUM-1:0][PORT_W-1:0]   req_Port,
    input  logic [PORT_NUM*VC_NUM-1:0]       vc_Release,
    output logic [REQ_NUM-1:0]               vc_Val,
    output logic [REQ_NUM-1:0][VC_Size-1:0]  vc_New,
    output logic [PORT_NUM*VC_NUM-1:0]       vc_Free,
    output logic                             err
);
    import params_noc::*;

    localparam int FREE_W = $clog2(PORT_NUM * VC_NUM);

    logic [REQ_NUM-1:0]                eligible;
    logic [REQ_NUM-1:0]                illegal;
    logic [PORT_NUM-1:0][REQ_NUM-1:0]  cand;
    logic [PORT_NUM-1:0][REQ_NUM-1:0]  grant;
    logic [PORT_NUM-1:0]               grant_valid;
    logic [PORT_NUM-1:0]               any_free;
    logic [PORT_NUM-1:0][VC_Size-1:0]  low_vc;
    logic [REQ_NUM-1:0]                val_next;
    logic [REQ_NUM-1:0][VC_Size-1:0]   new_next;
    logic [PORT_NUM*VC_NUM-1:0]        free_next;
    logic                              err_next;

    // Masking with vc_Val stops a second grant while the requester still holds vc_Req.
    always_comb begin
        eligible = vc_Req & ~vc_Val;
        illegal  = '0;
        cand     = '0;
        for (int r = 0; r < REQ_NUM; r++) begin
            illegal[r] = vc_Req[r] && (int'(req_Port[r]) >= PORT_NUM);
            for (int p = 0; p < PORT_NUM; p++) begin
                cand[p][r] = eligible[r] && (int'(req_Port[r]) == p);
            end
        end
    end

    always_comb begin
        any_free = '0;
        low_vc   = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = VC_NUM - 1; v >= 0; v--) begin
                if (vc_Free[FREE_W'(pack_idx(p, v, VC_NUM))]) begin
                    any_free[p] = 1'b1;
                    low_vc[p]   = VC_Size'(v);
                end
            end
        end
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        rr_arbiter #(.N(REQ_NUM)) u_arb (
            .clk         (clk),
            .rst         (rst),
            .req         (cand[p]),
            .advance     (any_free[p]),
            .grant       (grant[p]),
            .grant_valid (grant_valid[p])
        );
    end

    // Releases are applied before grant clears; a granted VC is always currently free.
    always_comb begin
        val_next  = '0;
        new_next  = '0;
        free_next = vc_Free | vc_Release;
        err_next  = (|(vc_Release & vc_Free)) | (|illegal);
        for (int p = 0; p < PORT_NUM; p++) begin
            if (grant_valid[p] && any_free[p]) begin
                val_next = val_next | grant[p];
                for (int r = 0; r < REQ_NUM; r++) begin
                    if (grant[p][r]) new_next[r] = low_vc[p];
                end
                free_next[FREE_W'(pack_idx(p, int'(low_vc[p]), VC_NUM))] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vc_Val  <= '0;
            vc_New  <= '0;
            vc_Free <= '1;
            err     <= 1'b0;
        end else begin
            vc_Val  <= val_next;
            vc_New  <= new_next;
            vc_Free <= free_next;
            err     <= err_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/vc_allocator.md
Name: vc_allocator

Overview:
- Router-level virtual-channel allocator. It sits between the per-VC input status buffers and the downstream routers' VC pools.
- It collects VC requests from every input VC. Each request carries a requested output port, which the route computation has already decided.
- It tracks which downstream VCs are free on each output port and grants one free downstream VC per output port per cycle, using round-robin fairness.
- Downstream VCs return to the pool when the router reports that the packet's tail has been released.

Parameters:
- PORT_NUM, 5, number of router ports (LOCAL, NORTH, SOUTH, EAST, WEST); requester and output-port count.
- VC_NUM, 2, VCs per port. VC_Size = $clog2(VC_NUM) is taken from params_noc.
- REQ_NUM, PORT_NUM*VC_NUM, derived; requester index = in_port*VC_NUM + in_vc.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset (synchronous, active-high).
- vc_Req, input, REQ_NUM, per-requester request level. Held high until vc_Val is seen.
- req_Port, input, REQ_NUM x inout_Port, requested output port per requester. Valid while vc_Req is high.
- vc_Release, input, PORT_NUM*VC_NUM, one-cycle pulse that frees downstream VC [out_port*VC_NUM + vc].
- vc_Val, output, REQ_NUM, one-cycle grant pulse per requester.
- vc_New, output, REQ_NUM x VC_Size, granted downstream VC index. Valid when vc_Val is high.
- vc_Free, output, PORT_NUM*VC_NUM, registered availability table, for observability.
- err, output, 1, registered one-cycle error pulse.

Behaviour:
- Clock and reset:
  - Single clock clk. Synchronous, active-high rst.
  - On reset: vc_Free = all 1s, vc_Val = 0, vc_New = 0, err = 0, every round-robin pointer = 0.
  - When rst is asserted mid-operation, all grants in flight are dropped. The requester side is responsible for resetting itself at the same time.
- Eligibility:
  - Requester r is eligible in cycle t when vc_Req[r]=1 and vc_Val[r]=0.
  - The vc_Val mask prevents a double grant in the cycle where the requester still has vc_Req high after being granted.
- Per output port p, each cycle:
  - The candidate set is the eligible requesters with req_Port[r]==p.
  - If the candidate set is non-empty and at least one vc_Free[p][*] is 1:
    - Pick the winner by round-robin, starting from ptr[p].
    - Assign the lowest-index free VC v.
    - Next cycle: vc_Val[winner]=1, vc_New[winner]=v, vc_Free[p][v]=0, ptr[p]=winner+1 modulo REQ_NUM.
  - If no VC is free, no grant is made, ptr[p] is unchanged, and requests wait. This is not an error.
- Latency: the grant appears exactly one cycle after the request is sampled. Throughput is one grant per output port per cycle; up to PORT_NUM grants can issue in the same cycle.
- Losers keep vc_Req high and are reconsidered next cycle. A requester can never receive two grants for one request.
- Release:
  - vc_Release[p][v] sets vc_Free[p][v]=1 on the next edge.
  - Allocation in cycle t uses the vc_Free value registered at t. A VC released in cycle t is therefore grantable no earlier than t+1.
  - Same-cycle release and grant of different VCs on the same port both take effect.
- Errors (err=1 next cycle, state otherwise unaffected):
  - vc_Release of an entry that is already free. The entry stays 1.
  - vc_Req high with req_Port outside LOCAL..WEST. That requester is ignored.
- Width rules: the pointer is $clog2(REQ_NUM) bits and wraps explicitly at REQ_NUM-1 to 0, not at a power of 2.
- vc_Val and vc_New are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- params_noc provides: VC_Size, VC_NUM, PORT_NUM, the inout_Port enum, and a req_idx/port/vc packing helper function.
- Sub-module rr_arbiter #(N): request vector, registered pointer, one-hot grant, and a grant_valid flag.
  - vc_allocator instantiates one rr_arbiter per output port.
  - It adds the requester-to-port steering, the lowest-free-VC priority encoder, the vc_Free table, and error logic.

Test Plan:
- Reset then idle: vc_Free=10'h3FF, vc_Val=0, err=0 for 5 cycles.
- Single request: requester 0 (LOCAL VC0) with req_Port=EAST at t. Required: vc_Val[0]=1 with vc_New=0 at t+1, only for 1 cycle, even though vc_Req is held through t+1. vc_Free[EAST][0]=0.
- Contention: requesters 2, 4 and 6 all target NORTH from t, with VC_NUM=2. Required:
  - t+1: grant to 2, VC0.
  - t+2: grant to 4, VC1.
  - Requester 6 stalls until vc_Release[NORTH][0] at t+5, then is granted VC0 at t+7 (the table updates at t+6).
- Parallel ports: requesters to LOCAL, SOUTH and WEST in the same cycle. Required: all three vc_Val pulses occur in the same cycle, each with vc_New=0.
- Fairness: requesters 1 and 3 continuously target EAST, with the granted VC released 1 cycle after each grant. Required: grants alternate 1,3,1,3, and neither requester goes more than one grant without service.
- Errors:
  - Release of an already-free VC: err pulses for 1 cycle and vc_Free is unchanged.
  - Illegal req_Port value 3'b111: err pulses and no vc_Val is issued.
  - rst asserted mid-grant: vc_Val=0 on the next cycle and the table is all free.
